conv_table_loader: RTL
======================

Name: conv_table_loader

Overview:
Writable 256-entry lookup table that holds the conversion data the ROM-based converter uses, loaded at run time instead of through an init file.
- Load side: accepts a byte stream over a valid/ready handshake and writes it sequentially into block RAM with a running checksum.
- Lookup side: serves synchronous reads with the same 1-cycle latency as the ROM path.
- Sits between a host or UART byte source and the display/conversion datapath.

Parameters:
ADDR_W, 8, table address width; depth = 2**ADDR_W
DATA_W, 8, table entry width and stream byte width

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
load_start  input  1  single-cycle pulse; begins or restarts a table load
s_valid  input  1  stream byte valid
s_data  input  DATA_W  stream byte
s_ready  output  1  loader accepts byte this cycle
load_busy  output  1  high while in LOAD
load_done  output  1  one-cycle pulse when the last entry is written
csum  output  DATA_W  running modulo-2**DATA_W sum of accepted bytes
lookup_en  input  1  read request
lookup_addr  input  ADDR_W  read address
lookup_data  output  DATA_W  registered read data
lookup_valid  output  1  lookup_data is valid this cycle
table_ready  output  1  table holds a complete load

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; wr_ptr=0; csum=0.
  - s_ready=0, load_busy=0, load_done=0, lookup_valid=0, lookup_data=0, table_ready=0.
  - RAM contents are not cleared (block RAM, rom_style block equivalent: ram_style "block").
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - s_ready=0.
  - load_start=1 -> next LOAD; wr_ptr<=0; csum<=0; table_ready<=0.
- LOAD:
  - s_ready=1 and load_busy=1, both combinational from state.
  - Beat = s_valid && s_ready. On a beat: mem[wr_ptr]<=s_data; wr_ptr<=wr_ptr+1; csum<=csum+s_data, truncated to DATA_W.
  - Beat with wr_ptr==2**ADDR_W-1 -> next DONE; wr_ptr wraps to 0.
  - s_valid low -> hold; no timeout.
- DONE (one cycle):
  - load_done=1; table_ready<=1; s_ready=0; next IDLE.
- load_start while in LOAD: restart. wr_ptr<=0, csum<=0, stay in LOAD. A beat in the same cycle is discarded: no write, no csum update.
- load_start while in DONE: ignored.
- load_start in IDLE with table_ready=1: clears table_ready on the next edge.
- Lookup:
  - lookup_en && table_ready at edge N -> lookup_data=mem[lookup_addr] and lookup_valid=1 at edge N+1.
  - lookup_en=0 or table_ready=0 -> lookup_valid<=0; lookup_data holds its last value.
  - Lookups are therefore blocked for the whole of LOAD and DONE.
  - Back-to-back lookups give one result per cycle.
- Read and write never collide, because lookups are gated by table_ready.
- Reset asserted mid-load: immediate return to IDLE, table_ready=0. Partially written RAM is treated as invalid.

Optional Feature:
CSUM_CHECK_EN
- Defined:
  - Adds input exp_csum [DATA_W] and output csum_err [1], csum_err reset value 0.
  - In DONE, compare csum including the final byte against exp_csum.
  - Match -> table_ready<=1, csum_err<=0.
  - Mismatch -> table_ready stays 0, csum_err<=1.
  - csum_err clears on the next load_start.
  - load_done pulses in both cases.
- Undefined: ports absent; table_ready set unconditionally in DONE.

Test Plan:
- Reset, then lookup_en=1 addr=0x10 -> lookup_valid stays 0; s_ready=0; all outputs 0.
- Full load: load_start, then 256 back-to-back beats with s_data=addr[7:0] -> load_done pulses exactly once, on the cycle after beat 255; csum=0x80; table_ready=1. Lookups at 0x00, 0x7F, 0xFF return 0x00, 0x7F, 0xFF with 1-cycle latency.
- Stalled stream: s_valid toggled 1,0,0,1 throughout the load -> writes occur only on valid cycles; final RAM contents and csum identical to the unstalled case.
- Restart: after 100 beats, pulse load_start together with s_valid=1 s_data=0xAA -> that byte is dropped; wr_ptr=0, csum=0; the next 256 bytes fully define the table.
- Reset mid-load (reset_n low at beat 50) -> immediate IDLE, table_ready=0, load_busy=0; a subsequent full load completes normally.
- CSUM_CHECK_EN defined:
  - exp_csum=0x80 with the identity load -> table_ready=1, csum_err=0.
  - exp_csum=0x81 -> table_ready=0, csum_err=1, lookups return lookup_valid=0.

Source files
------------

// File: rtl/conv_table_loader.sv
// conv_table_loader: run-time loadable 256-entry conversion table.
// Optional CSUM_CHECK_EN gates table_ready on a checksum match.
module conv_table_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic [DATA_W-1:0] csum,
    input  logic              lookup_en,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic [DATA_W-1:0] lookup_data,
    output logic              lookup_valid,
`ifdef CSUM_CHECK_EN
    input  logic [DATA_W-1:0] exp_csum,
    output logic              csum_err,
`endif
    output logic              table_ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_en;
    logic              rd_en;

    (* ram_style = "block" *)
    logic [DATA_W-1:0] mem [DEPTH];

    assign s_ready   = (state == LOAD);
    assign load_busy = (state == LOAD);

    // A restart pulse wins over a beat in the same cycle.
    assign wr_en = (state == LOAD) && s_valid && !load_start;
    assign rd_en = lookup_en && table_ready;

    // Load sequencing: pointer, checksum, completion and table status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            csum        <= '0;
            load_done   <= 1'b0;
            table_ready <= 1'b0;
`ifdef CSUM_CHECK_EN
            csum_err    <= 1'b0;
`endif
        end else begin
            load_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_start) begin
                        state       <= LOAD;
                        wr_ptr      <= '0;
                        csum        <= '0;
                        table_ready <= 1'b0;
`ifdef CSUM_CHECK_EN
                        csum_err    <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        wr_ptr   <= '0;
                        csum     <= '0;
`ifdef CSUM_CHECK_EN
                        csum_err <= 1'b0;
`endif
                    end else if (s_valid) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        csum   <= csum + s_data;
                        if (wr_ptr == LAST) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef CSUM_CHECK_EN
                    table_ready <= (csum == exp_csum);
                    csum_err    <= (csum != exp_csum);
`else
                    table_ready <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Table write port; contents survive reset like any block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Registered lookup, one-cycle latency, data held when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lookup_valid <= 1'b0;
            lookup_data  <= '0;
        end else begin
            lookup_valid <= rd_en;
            if (rd_en) begin
                lookup_data <= mem[lookup_addr];
            end
        end
    end

endmodule
